// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, limits and helpers for the multi-cycle hazard unit
//
// Purpose : common definitions for hazard_unit_mc and load_tracker.
// Contents: default register-index width, pending-load slot struct,
//           parameter range limits, slot match helper.

package hazard_pkg;

   localparam int REG_NUM_BITWIDTH_DEFAULT = 5;

   // Slots carry register indices at a fixed maximum width so the struct
   // does not depend on the instantiating module's parameters.
   localparam int RD_MAX_BITS = 8;

   localparam int LOAD_LATENCY_MIN = 1;
   localparam int LOAD_LATENCY_MAX = 8;
   localparam int FLUSH_CYCLES_MIN = 1;
   localparam int FLUSH_CYCLES_MAX = 4;

   typedef logic [RD_MAX_BITS-1:0] pending_rd_t;

   typedef struct packed {
      logic        valid;
      pending_rd_t rd;
   } pending_load_t;

   // x0 is never a real dependency: a slot naming x0 never hits even if
   // something upstream marked it valid.
   function automatic logic slot_hits(input pending_load_t s,
                                      input pending_rd_t   src1,
                                      input pending_rd_t   src2);
      return s.valid && (s.rd != '0) && ((s.rd == src1) || (s.rd == src2));
   endfunction

endpackage

// File: rtl/load_tracker.sv
// rtl/load_tracker.sv - shift chain of in-flight loads with per-slot source match
//
// Purpose : slot 0 is the load currently in EX (combinational); slots
//           1..LOAD_LATENCY-1 are loads that left EX 1..LOAD_LATENCY-1
//           cycles ago. Every slot is compared against both decode sources.
// Ports   : clk, rst        clock, async active-high reset
//           load_valid      instruction in EX is a load
//           load_rd         destination of the instruction in EX
//           src1, src2      source indices of the instruction in decode
//           match_vec       bit k set when slot k hits src1 or src2

module load_tracker
   import hazard_pkg::*;
#(
   parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEFAULT,
   parameter int LOAD_LATENCY     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load_valid,
   input  logic [REG_NUM_BITWIDTH-1:0] load_rd,
   input  logic [REG_NUM_BITWIDTH-1:0] src1,
   input  logic [REG_NUM_BITWIDTH-1:0] src2,
   output logic [LOAD_LATENCY-1:0]     match_vec
);

   pending_load_t slot0;
   pending_rd_t   src1_ext;
   pending_rd_t   src2_ext;
   logic          slot0_hit;

   assign src1_ext = pending_rd_t'(src1);
   assign src2_ext = pending_rd_t'(src2);

   // A load to x0 never becomes a pending entry.
   assign slot0.valid = load_valid && (load_rd != '0);
   assign slot0.rd    = pending_rd_t'(load_rd);

   assign slot0_hit = slot_hits(slot0, src1_ext, src2_ext);

   if (LOAD_LATENCY > 1) begin : g_chain
      // chain_q[k] holds slot k+1.
      pending_load_t [LOAD_LATENCY-2:0] chain_q;
      logic          [LOAD_LATENCY-2:0] chain_hit;

      // Loads always advance out of EX, so the chain shifts every cycle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            chain_q <= '0;
         end else begin
            chain_q[0] <= slot0;
            for (int k = 1; k < LOAD_LATENCY - 1; k++) begin
               chain_q[k] <= chain_q[k-1];
            end
         end
      end

      always_comb begin
         chain_hit = '0;
         for (int k = 0; k < LOAD_LATENCY - 1; k++) begin
            chain_hit[k] = slot_hits(chain_q[k], src1_ext, src2_ext);
         end
      end

      assign match_vec = {chain_hit, slot0_hit};
   end else begin : g_no_chain
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign match_vec      = slot0_hit;
   end

endmodule

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - multi-cycle load-use hazard and branch-flush controller
//
// Purpose : stalls a decode instruction that depends on a load still within
//           LOAD_LATENCY cycles of EX, stretches a taken redirect into
//           FLUSH_CYCLES cycles of front-end NOPs, counts data-stall cycles.
// Ports   : clk, rst              clock, async active-high reset
//           id_memRead, id_Rd     load flag and destination of instruction in EX
//           if_Rs1, if_Rs2        sources of instruction in decode
//           PCSrc                 redirect taken this cycle
//           if_write, PCWrite     1 = IF/ID and PC may update, 0 = hold
//           if_doNOP              squash IF/ID contents
//           id_doNOP              inject bubble into ID/EX
//           stall_cycles          saturating data-stall cycle count

module hazard_unit_mc
   import hazard_pkg::*;
#(
   parameter int REG_NUM_BITWIDTH = REG_NUM_BITWIDTH_DEFAULT,
   parameter int WORD_BITWIDTH    = 32,
   parameter int LOAD_LATENCY     = 1,
   parameter int FLUSH_CYCLES     = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        id_memRead,
   input  logic [REG_NUM_BITWIDTH-1:0] id_Rd,
   input  logic [REG_NUM_BITWIDTH-1:0] if_Rs1,
   input  logic [REG_NUM_BITWIDTH-1:0] if_Rs2,
   input  logic                        PCSrc,
   output logic                        if_write,
   output logic                        PCWrite,
   output logic                        if_doNOP,
   output logic                        id_doNOP,
   output logic [WORD_BITWIDTH-1:0]    stall_cycles
);

   if ((LOAD_LATENCY < LOAD_LATENCY_MIN) || (LOAD_LATENCY > LOAD_LATENCY_MAX) ||
       (FLUSH_CYCLES < FLUSH_CYCLES_MIN) || (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ||
       (REG_NUM_BITWIDTH < 1) || (REG_NUM_BITWIDTH > RD_MAX_BITS) ||
       (WORD_BITWIDTH < 1)) begin : g_param_check
      $error("hazard_unit_mc: parameter out of supported range");
   end

   logic [LOAD_LATENCY-1:0] match_vec;
   logic                    match;
   logic                    flush_busy;
   logic                    flush_active;
   logic                    data_hazard;

   load_tracker #(
      .REG_NUM_BITWIDTH (REG_NUM_BITWIDTH),
      .LOAD_LATENCY     (LOAD_LATENCY)
   ) u_load_tracker (
      .clk        (clk),
      .rst        (rst),
      .load_valid (id_memRead),
      .load_rd    (id_Rd),
      .src1       (if_Rs1),
      .src2       (if_Rs2),
      .match_vec  (match_vec)
   );

   assign match = |match_vec;

   // flush_cnt counts the remaining flush cycles after the redirect cycle.
   // A redirect during a flush reloads rather than accumulates.
   if (FLUSH_CYCLES > 1) begin : g_flush_cnt
      localparam int FCW = $clog2(FLUSH_CYCLES);
      logic [FCW-1:0] flush_cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            flush_cnt <= '0;
         end else if (PCSrc) begin
            flush_cnt <= FCW'(FLUSH_CYCLES - 1);
         end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FCW'(1);
         end
      end

      assign flush_busy = (flush_cnt != '0);
   end else begin : g_no_flush_cnt
      assign flush_busy = 1'b0;
   end

   assign flush_active = PCSrc || flush_busy;

   // The flush discards the dependent instruction, so stalling it is pointless.
   assign data_hazard = match && !flush_active;

   assign if_write = !data_hazard;
   assign PCWrite  = !data_hazard;
   assign id_doNOP = data_hazard || flush_active;
   assign if_doNOP = flush_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (data_hazard && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + WORD_BITWIDTH'(1);
      end
   end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
Pipeline hazard controller for the 5-stage RISC-V core, and the successor to the single-cycle load-use hazard unit. It detects load-use hazards for loads whose result arrives LOAD_LATENCY cycles after leaving EX, and keeps a registered tracker of in-flight loads. Branch flushes are stretched over FLUSH_CYCLES cycles for deeper front ends, and stalled cycles are counted for performance analysis. Naming: if_* is the IF/ID register (instruction in decode); id_* is the ID/EX register (instruction in EX).

Parameters:
REG_NUM_BITWIDTH, 5, register-index width.
WORD_BITWIDTH, 32, width of the stall counter.
LOAD_LATENCY, 1, cycles a dependent must wait behind a load in EX (1..8); 1 reproduces classic load-use.
FLUSH_CYCLES, 1, cycles of front-end NOP per taken branch/jump (1..4).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
id_memRead  in  1  instruction in EX is a load.
id_Rd  in  REG_NUM_BITWIDTH  destination of instruction in EX.
if_Rs1  in  REG_NUM_BITWIDTH  source 1 of instruction in decode.
if_Rs2  in  REG_NUM_BITWIDTH  source 2 of instruction in decode.
PCSrc  in  1  redirect taken this cycle.
if_write  out  1  1 = IF/ID register may load; 0 = hold.
PCWrite  out  1  1 = PC may update; 0 = hold.
if_doNOP  out  1  replace IF/ID contents with NOP.
id_doNOP  out  1  replace ID/EX input with NOP (bubble).
stall_cycles  out  WORD_BITWIDTH  saturating count of data-stall cycles.

Behaviour:
- Tracker: LOAD_LATENCY slots. Slot 0 is combinational {id_memRead && id_Rd!=0, id_Rd}. Slots 1..LOAD_LATENCY-1 are registered and shift by one each cycle: slot1 <= slot0, slot[k+1] <= slot[k]. The oldest slot drops out. Shifting is unconditional, because a load in EX always advances.
- match = any valid slot whose rd equals if_Rs1 or if_Rs2. Register x0 never matches.
- flush_active = PCSrc || (flush_cnt != 0).
- flush_cnt: when PCSrc=1, load FLUSH_CYCLES-1. Otherwise decrement while nonzero. A new PCSrc during a flush reloads the counter (no accumulation).
- dataHazard = match && !flush_active. A flush has priority: it discards the dependent instruction, so no stall is taken.
- Outputs:
  - if_write = PCWrite = !dataHazard.
  - id_doNOP = dataHazard || flush_active.
  - if_doNOP = flush_active.
- Latency: a dependent in decode behind a load entering EX stalls exactly LOAD_LATENCY cycles. No stall occurs if the dependent arrives k cycles later and k >= LOAD_LATENCY.
- stall_cycles increments on every cycle with dataHazard=1 and saturates at all-ones.
- Reset (asynchronous, any time including mid-stall or mid-flush): all slots invalid, flush_cnt=0, stall_cycles=0. With inputs at 0, outputs are if_write=1, PCWrite=1, if_doNOP=0, id_doNOP=0.
- LOAD_LATENCY=1 has no registered slots. FLUSH_CYCLES=1 has no counter state, so the block degenerates to single-cycle flush.
- No X propagation: all outputs are defined when inputs are known.

Decomposition:
- Package hazard_pkg:
  - REG_NUM_BITWIDTH default.
  - The pending-load struct {valid, rd}.
  - Parameter range-check constants.
- Sub-module load_tracker:
  - Parametrised shift chain of pending-load slots.
  - Outputs a match vector against two source indices.
  - Implements the x0 exclusion.
- The top level holds the flush counter, priority logic and stall counter.

Test Plan:
- LOAD_LATENCY=1: load x5 in EX, decode uses x5 as Rs2 -> one cycle with if_write=0, PCWrite=0, id_doNOP=1; stall_cycles=1.
- LOAD_LATENCY=3: load x7 in EX, dependent decode on Rs1=x7 held -> exactly 3 stall cycles, then release. Dependent arriving 2 cycles after the load -> 1 stall cycle. Arriving 3 cycles after -> 0.
- Load with Rd=x0 and decode Rs1=x0 -> no stall for any LOAD_LATENCY.
- FLUSH_CYCLES=3: PCSrc pulse -> if_doNOP=id_doNOP=1 for 3 cycles. A second PCSrc in cycle 2 extends the flush to cycle 4. A load-use match during the flush -> PCWrite stays 1 and stall_cycles is unchanged.
- Reset mid-operation: assert rst during the 2nd stall cycle (LOAD_LATENCY=3) -> outputs return to if_write=1/PCWrite=1 immediately; after deassert, no residual stall; stall_cycles=0.
- WORD_BITWIDTH=4: force 20 consecutive stall cycles -> stall_cycles saturates at 15.
